// File: rtl/cnn_job_dispatcher.sv
// Job dispatcher for the CNN start/done interface: queues {x,y,z} jobs, launches them
// one at a time with a single-cycle start pulse, retires on done or watchdog abort.
module cnn_job_dispatcher #(
    parameter int N       = 4,
    parameter int AW      = $clog2(N*16+256),
    parameter int ZW      = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [AW-1:0] job_x,
    input  logic [AW-1:0] job_y,
    input  logic [ZW-1:0] job_z,
    output logic          cnn_start,
    output logic [AW-1:0] cnn_x,
    output logic [AW-1:0] cnn_y,
    output logic [ZW-1:0] cnn_z,
    input  logic          cnn_done,
    output logic          res_valid,
    output logic          res_timeout,
    output logic [15:0]   jobs_done,
    output logic          busy,
    output logic          err,
    input  logic          clr_err
);

    localparam int PW  = $clog2(DEPTH);
    localparam int EW  = 2*AW + ZW;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit   WD_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_HALT
    } state_t;

    state_t          state_reg, state_next;
    logic [PW:0]     wr_ptr_reg, rd_ptr_reg;
    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [EW-1:0]   fifo_head;
    logic            fifo_empty, fifo_full;
    logic            push, pop;
    logic [WDW-1:0]  wd_cnt_reg, wd_cnt_next;
    logic            retire_ok, retire_to;

    logic [AW-1:0]   cnn_x_reg, cnn_y_reg;
    logic [ZW-1:0]   cnn_z_reg;
    logic            res_valid_reg, res_timeout_reg;
    logic [15:0]     jobs_done_reg;
    logic            err_reg;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                        (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign push       = job_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_reg[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PW-1:0]] <= {job_x, job_y, job_z};
        end
    end

    always_comb begin
        state_next  = state_reg;
        wd_cnt_next = wd_cnt_reg;
        pop         = 1'b0;
        retire_ok   = 1'b0;
        retire_to   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                wd_cnt_next = '0;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final watchdog cycle still counts as success.
                if (cnn_done) begin
                    retire_ok  = 1'b1;
                    state_next = S_IDLE;
                end else if (WD_EN && (wd_cnt_reg == WD_LAST)) begin
                    retire_to  = 1'b1;
                    state_next = S_HALT;
                end else begin
                    wd_cnt_next = wd_cnt_reg + WDW'(1);
                end
            end
            S_HALT: begin
                if (clr_err) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            wd_cnt_reg      <= '0;
            cnn_x_reg       <= '0;
            cnn_y_reg       <= '0;
            cnn_z_reg       <= '0;
            res_valid_reg   <= 1'b0;
            res_timeout_reg <= 1'b0;
            jobs_done_reg   <= '0;
            err_reg         <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wd_cnt_reg <= wd_cnt_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
            end
            // The launch registers move only on IDLE->START, keeping them stable until retire.
            if (pop) begin
                rd_ptr_reg                        <= rd_ptr_reg + (PW+1)'(1);
                {cnn_x_reg, cnn_y_reg, cnn_z_reg} <= fifo_head;
            end
            res_valid_reg   <= retire_ok || retire_to;
            res_timeout_reg <= retire_to;
            if (retire_ok) begin
                jobs_done_reg <= jobs_done_reg + 16'd1;
            end
            if (retire_to) begin
                err_reg <= 1'b1;
            end else if (clr_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign job_ready   = !fifo_full;
    assign cnn_start   = (state_reg == S_START);
    assign cnn_x       = cnn_x_reg;
    assign cnn_y       = cnn_y_reg;
    assign cnn_z       = cnn_z_reg;
    assign res_valid   = res_valid_reg;
    assign res_timeout = res_timeout_reg;
    assign jobs_done   = jobs_done_reg;
    assign busy        = (state_reg != S_IDLE) || !fifo_empty;
    assign err         = err_reg;

endmodule

// File: tb/tb_cnn_job_dispatcher.sv
// Bench for cnn_job_dispatcher: scenario tasks with a queue-based reference of launches,
// retire timing and completion count; a second instance with a short watchdog.
module tb_cnn_job_dispatcher;

    localparam int AW  = 9;
    localparam int ZW  = 8;
    localparam int TO2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          job_valid, job_ready, cnn_start, cnn_done;
    logic          res_valid, res_timeout, busy, err, clr_err;
    logic [AW-1:0] job_x, job_y, cnn_x, cnn_y;
    logic [ZW-1:0] job_z, cnn_z;
    logic [15:0]   jobs_done;

    logic          w_job_valid, w_job_ready, w_cnn_start, w_cnn_done;
    logic          w_res_valid, w_res_timeout, w_busy, w_err, w_clr_err;
    logic [AW-1:0] w_job_x, w_job_y, w_cnn_x, w_cnn_y;
    logic [ZW-1:0] w_job_z, w_cnn_z;
    logic [15:0]   w_jobs_done;

    cnn_job_dispatcher #(.N(4)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_x(job_x), .job_y(job_y), .job_z(job_z), .cnn_start(cnn_start),
        .cnn_x(cnn_x), .cnn_y(cnn_y), .cnn_z(cnn_z), .cnn_done(cnn_done),
        .res_valid(res_valid), .res_timeout(res_timeout), .jobs_done(jobs_done),
        .busy(busy), .err(err), .clr_err(clr_err)
    );

    cnn_job_dispatcher #(.N(4), .TIMEOUT(TO2)) dut_wd (
        .clk(clk), .rst(rst), .job_valid(w_job_valid), .job_ready(w_job_ready),
        .job_x(w_job_x), .job_y(w_job_y), .job_z(w_job_z), .cnn_start(w_cnn_start),
        .cnn_x(w_cnn_x), .cnn_y(w_cnn_y), .cnn_z(w_cnn_z), .cnn_done(w_cnn_done),
        .res_valid(w_res_valid), .res_timeout(w_res_timeout), .jobs_done(w_jobs_done),
        .busy(w_busy), .err(w_err), .clr_err(w_clr_err)
    );

    typedef struct { logic [AW-1:0] x; logic [AW-1:0] y; logic [ZW-1:0] z; } job_t;
    typedef struct { logic [AW-1:0] x; logic [AW-1:0] y; logic [ZW-1:0] z; int c; } start_t;
    typedef struct { logic to; logic [15:0] cnt; int c; } res_t;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     exp_jobs = 0;
    start_t starts_q[$];
    res_t   res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observed launches and retirements of the main instance, one line each.
    always @(negedge clk) begin
        if (cnn_start === 1'b1) begin
            starts_q.push_back('{cnn_x, cnn_y, cnn_z, cyc});
            $display("[%0d] start x=%0d y=%0d z=%0d", cyc, cnn_x, cnn_y, cnn_z);
        end
        if (res_valid === 1'b1) begin
            res_q.push_back('{res_timeout, jobs_done, cyc});
            $display("[%0d] retire timeout=%0b jobs_done=%0d", cyc, res_timeout, jobs_done);
        end
    end

    function automatic job_t rand_job();
        job_t j;
        j.x = AW'($urandom());
        j.y = AW'($urandom());
        j.z = ZW'($urandom());
        return j;
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic push_job(input job_t j, output bit ok);
        job_valid = 1'b1;
        job_x = j.x; job_y = j.y; job_z = j.z;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (job_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    // CNN model: done is raised after lat low WAIT cycles following launch idx, for one cycle.
    task automatic serve_one(input int idx, input int lat, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300 && starts_q.size() <= idx; t++) @(negedge clk);
        if (starts_q.size() > idx) begin
            ok = 1'b1;
            while (cyc < starts_q[idx].c + 1 + lat) @(negedge clk);
            cnn_done = 1'b1;
            @(negedge clk);
            cnn_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({job_ready, cnn_start, res_valid, res_timeout, busy, err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {job_ready, cnn_start, res_valid, res_timeout, busy, err});
        end
        n_checks++;
        if ({cnn_x, cnn_y, cnn_z, jobs_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: x=%0d y=%0d z=%0d jobs_done=%0d expected all 0",
                     cnn_x, cnn_y, cnn_z, jobs_done);
        end
        n_checks++;
        if ({w_job_ready, w_busy, w_err, w_jobs_done} !== {3'b100, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_wd: ready=%b busy=%b err=%b jobs_done=%0d expected 1 0 0 0",
                     w_job_ready, w_busy, w_err, w_jobs_done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        job_t j;
        bit ok, held;
        int sc;
        j.x = 9'd64; j.y = 9'd0; j.z = 8'd0;
        push_job(j, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL single_push: accepted=%b expected 1", ok); end
        n_checks++;
        if (cnn_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b expected 0", cnn_start); end
        @(negedge clk);
        sc = cyc;
        n_checks++;
        if ({cnn_start, cnn_x, cnn_y, cnn_z} !== {1'b1, 9'd64, 9'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL single_launch: start=%b x=%0d y=%0d z=%0d expected 1 64 0 0",
                     cnn_start, cnn_x, cnn_y, cnn_z);
        end
        held = 1'b1;
        while (cyc < sc + 20) begin
            @(negedge clk);
            if (cnn_start !== 1'b0 || cnn_x !== 9'd64 || cnn_y !== 9'd0 || cnn_z !== 8'd0 ||
                res_valid !== 1'b0 || busy !== 1'b1) held = 1'b0;
        end
        n_checks++;
        if (held !== 1'b1) begin n_fail++; $display("FAIL single_hold: stable=%b expected 1", held); end
        cnn_done = 1'b1;
        @(negedge clk);
        cnn_done = 1'b0;
        exp_jobs++;
        n_checks++;
        if ({res_valid, res_timeout, busy} !== 3'b100 || jobs_done !== 16'(exp_jobs)) begin
            n_fail++;
            $display("FAIL single_retire: valid=%b timeout=%b busy=%b jobs_done=%0d expected 1 0 0 %0d",
                     res_valid, res_timeout, busy, jobs_done, exp_jobs);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: res_valid=%b expected 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        job_t jobs[3];
        bit ok, all_ok;
        int base, rbase, lat;
        base = starts_q.size(); rbase = res_q.size();
        lat = $urandom_range(2, 8);
        all_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            jobs[i] = rand_job();
            jobs[i].x = AW'(64 * (i + 1));
        end
        for (int i = 0; i < 3; i++) begin push_job(jobs[i], ok); all_ok &= ok; end
        for (int i = 0; i < 3; i++) begin serve_one(base + i, lat, ok); all_ok &= ok; end
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_ok !== 1'b1 || starts_q.size() != base + 3 || res_q.size() != rbase + 3) begin
            n_fail++;
            $display("FAIL b2b_counts: ok=%b starts=%0d retires=%0d expected 1 3 3",
                     all_ok, starts_q.size() - base, res_q.size() - rbase);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({starts_q[base+i].x, starts_q[base+i].y, starts_q[base+i].z} !== {jobs[i].x, jobs[i].y, jobs[i].z}) begin
                    n_fail++;
                    $display("FAIL b2b_job%0d: x=%0d y=%0d z=%0d expected %0d %0d %0d", i,
                             starts_q[base+i].x, starts_q[base+i].y, starts_q[base+i].z, jobs[i].x, jobs[i].y, jobs[i].z);
                end
                n_checks++;
                if (res_q[rbase+i].to !== 1'b0 || res_q[rbase+i].cnt !== 16'(exp_jobs + i + 1) ||
                    res_q[rbase+i].c != starts_q[base+i].c + lat + 2) begin
                    n_fail++;
                    $display("FAIL b2b_retire%0d: timeout=%b count=%0d cycle=%0d expected 0 %0d %0d", i,
                             res_q[rbase+i].to, res_q[rbase+i].cnt, res_q[rbase+i].c, exp_jobs + i + 1,
                             starts_q[base+i].c + lat + 2);
                end
                if (i > 0) begin
                    n_checks++;
                    if (starts_q[base+i].c - starts_q[base+i-1].c != lat + 3) begin
                        n_fail++;
                        $display("FAIL b2b_spacing%0d: got %0d expected %0d", i,
                                 starts_q[base+i].c - starts_q[base+i-1].c, lat + 3);
                    end
                end
            end
        end
        exp_jobs += 3;
        n_checks++;
        if (jobs_done !== 16'(exp_jobs)) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", jobs_done, exp_jobs); end
    endtask

    task automatic test_backpressure();
        job_t jobs[6];
        bit ok, all_ok;
        int base, rbase;
        base = starts_q.size(); rbase = res_q.size();
        all_ok = 1'b1;
        for (int i = 0; i < 6; i++) jobs[i] = rand_job();
        for (int i = 0; i < 6; i++) begin
            job_valid = 1'b1;
            job_x = jobs[i].x; job_y = jobs[i].y; job_z = jobs[i].z;
            n_checks++;
            if (job_ready !== (i < 5)) begin
                n_fail++;
                $display("FAIL bp_ready%0d: got %b expected %b", i, job_ready, (i < 5));
            end
            if (i < 5) @(negedge clk);
        end
        serve_one(base, 10, ok);
        all_ok &= ok;
        n_checks++;
        if (job_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full: got %b expected 0", job_ready); end
        @(negedge clk);
        n_checks++;
        if (job_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b expected 1", job_ready); end
        @(negedge clk);
        job_valid = 1'b0;
        for (int i = 1; i < 6; i++) begin serve_one(base + i, $urandom_range(0, 5), ok); all_ok &= ok; end
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_ok !== 1'b1 || starts_q.size() != base + 6 || res_q.size() != rbase + 6) begin
            n_fail++;
            $display("FAIL bp_counts: ok=%b starts=%0d retires=%0d expected 1 6 6",
                     all_ok, starts_q.size() - base, res_q.size() - rbase);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if ({starts_q[base+i].x, starts_q[base+i].y, starts_q[base+i].z} !== {jobs[i].x, jobs[i].y, jobs[i].z} ||
                    res_q[rbase+i].to !== 1'b0 || res_q[rbase+i].cnt !== 16'(exp_jobs + i + 1)) begin
                    n_fail++;
                    $display("FAIL bp_job%0d: x=%0d count=%0d timeout=%b expected %0d %0d 0", i,
                             starts_q[base+i].x, res_q[rbase+i].cnt, res_q[rbase+i].to, jobs[i].x, exp_jobs + i + 1);
                end
            end
        end
        exp_jobs += 6;
    endtask

    task automatic test_stale_done();
        job_t j;
        bit ok;
        int base, rbase, sc;
        base = starts_q.size(); rbase = res_q.size();
        j = rand_job();
        push_job(j, ok);
        cnn_done = 1'b1;
        @(negedge clk);
        sc = cyc;
        n_checks++;
        if (ok !== 1'b1 || cnn_start !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_launch: accepted=%b start=%b expected 1 1", ok, cnn_start);
        end
        @(negedge clk);
        cnn_done = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL stale_ignored: res_valid=%b expected 0", res_valid); end
        @(negedge clk);
        @(negedge clk);
        cnn_done = 1'b1;
        repeat (5) @(negedge clk);
        cnn_done = 1'b0;
        @(negedge clk);
        exp_jobs++;
        n_checks++;
        if (res_q.size() != rbase + 1 || starts_q.size() != base + 1) begin
            n_fail++;
            $display("FAIL stale_counts: retires=%0d starts=%0d expected 1 1", res_q.size() - rbase, starts_q.size() - base);
        end else begin
            n_checks++;
            if (res_q[rbase].c != sc + 4 || res_q[rbase].cnt !== 16'(exp_jobs)) begin
                n_fail++;
                $display("FAIL stale_retire: cycle=%0d count=%0d expected %0d %0d", res_q[rbase].c, res_q[rbase].cnt, sc + 4, exp_jobs);
            end
        end
    endtask

    task automatic test_random();
        job_t jobs[12];
        int lats[12];
        int base, rbase, bad;
        base = starts_q.size(); rbase = res_q.size();
        bad = 0;
        for (int i = 0; i < 12; i++) begin jobs[i] = rand_job(); lats[i] = $urandom_range(0, 6); end
        fork
            begin
                bit pok;
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    push_job(jobs[i], pok);
                    if (!pok) bad++;
                end
            end
            begin
                bit sok;
                for (int k = 0; k < 12; k++) begin
                    serve_one(base + k, lats[k], sok);
                    if (!sok) bad++;
                end
            end
        join
        repeat (2) @(negedge clk);
        n_checks++;
        if (bad != 0 || starts_q.size() != base + 12 || res_q.size() != rbase + 12) begin
            n_fail++;
            $display("FAIL rand_counts: stalls=%0d starts=%0d retires=%0d expected 0 12 12",
                     bad, starts_q.size() - base, res_q.size() - rbase);
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if ({starts_q[base+i].x, starts_q[base+i].y, starts_q[base+i].z} !== {jobs[i].x, jobs[i].y, jobs[i].z} ||
                    res_q[rbase+i].to !== 1'b0 || res_q[rbase+i].cnt !== 16'(exp_jobs + i + 1) ||
                    res_q[rbase+i].c != starts_q[base+i].c + lats[i] + 2 ||
                    (i > 0 && starts_q[base+i].c - starts_q[base+i-1].c < lats[i-1] + 3)) begin
                    n_fail++;
                    $display("FAIL rand_job%0d: x=%0d count=%0d retire_cyc=%0d expected x=%0d count=%0d retire_cyc=%0d", i,
                             starts_q[base+i].x, res_q[rbase+i].cnt, res_q[rbase+i].c, jobs[i].x, exp_jobs + i + 1,
                             starts_q[base+i].c + lats[i] + 2);
                end
            end
        end
        exp_jobs += 12;
        n_checks++;
        if (jobs_done !== 16'(exp_jobs)) begin n_fail++; $display("FAIL rand_total: got %0d expected %0d", jobs_done, exp_jobs); end
    endtask

    task automatic test_timeout();
        job_t ja, jb;
        int sc, rc, extra;
        bit seen;
        ja = rand_job(); jb = rand_job();
        w_job_valid = 1'b1; w_job_x = ja.x; w_job_y = ja.y; w_job_z = ja.z;
        @(negedge clk);
        w_job_x = jb.x; w_job_y = jb.y; w_job_z = jb.z;
        @(negedge clk);
        w_job_valid = 1'b0;
        seen = 1'b0; sc = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (w_cnn_start === 1'b1) begin seen = 1'b1; sc = cyc; end else @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b1 || w_cnn_x !== ja.x) begin
            n_fail++;
            $display("FAIL to_launch: seen=%b x=%0d expected 1 %0d", seen, w_cnn_x, ja.x);
        end
        rc = -1;
        for (int t = 0; t < 40 && rc < 0; t++) begin
            @(negedge clk);
            if (w_res_valid === 1'b1) rc = cyc;
        end
        n_checks++;
        if (rc != sc + 1 + TO2) begin n_fail++; $display("FAIL to_cycle: retire at %0d expected %0d", rc, sc + 1 + TO2); end
        n_checks++;
        if ({w_res_timeout, w_err} !== 2'b11 || w_jobs_done !== 16'd0) begin
            n_fail++;
            $display("FAIL to_flags: timeout=%b err=%b jobs_done=%0d expected 1 1 0", w_res_timeout, w_err, w_jobs_done);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (w_cnn_start === 1'b1 || w_res_valid === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0 || w_err !== 1'b1 || w_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_halt: activity=%0d err=%b busy=%b expected 0 1 1", extra, w_err, w_busy);
        end
        w_clr_err = 1'b1;
        @(negedge clk);
        w_clr_err = 1'b0;
        n_checks++;
        if (w_err !== 1'b0) begin n_fail++; $display("FAIL to_clr: err=%b expected 0", w_err); end
        @(negedge clk);
        n_checks++;
        if (w_cnn_start !== 1'b1 || w_cnn_x !== jb.x) begin
            n_fail++;
            $display("FAIL to_resume: start=%b x=%0d expected 1 %0d", w_cnn_start, w_cnn_x, jb.x);
        end
        @(negedge clk);
        @(negedge clk);
        w_cnn_done = 1'b1;
        @(negedge clk);
        w_cnn_done = 1'b0;
        n_checks++;
        if ({w_res_valid, w_res_timeout, w_err} !== 3'b100 || w_jobs_done !== 16'd1) begin
            n_fail++;
            $display("FAIL to_after: valid=%b timeout=%b err=%b jobs_done=%0d expected 1 0 0 1",
                     w_res_valid, w_res_timeout, w_err, w_jobs_done);
        end
    endtask

    task automatic test_reset_mid_wait();
        job_t ja, jb, jc;
        bit ok, seen;
        int sbase, rbase;
        ja = rand_job(); jb = rand_job(); jc = rand_job();
        push_job(ja, ok);
        push_job(jb, ok);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (cnn_start === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (seen !== 1'b1 || {job_ready, cnn_start, res_valid, res_timeout, busy, err} !== 6'b100000 ||
            {cnn_x, cnn_y, cnn_z, jobs_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: launched=%b flags=%b x=%0d jobs_done=%0d expected 1 100000 0 0", seen,
                     {job_ready, cnn_start, res_valid, res_timeout, busy, err}, cnn_x, jobs_done);
        end
        sbase = starts_q.size(); rbase = res_q.size();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (starts_q.size() != sbase || res_q.size() != rbase || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_queue_lost: starts=%0d retires=%0d busy=%b expected 0 0 0",
                     starts_q.size() - sbase, res_q.size() - rbase, busy);
        end
        exp_jobs = 0;
        push_job(jc, ok);
        @(negedge clk);
        n_checks++;
        if (cnn_start !== 1'b1 || {cnn_x, cnn_y, cnn_z} !== {jc.x, jc.y, jc.z}) begin
            n_fail++;
            $display("FAIL rst_relaunch: start=%b x=%0d expected 1 %0d", cnn_start, cnn_x, jc.x);
        end
        @(negedge clk);
        cnn_done = 1'b1;
        @(negedge clk);
        cnn_done = 1'b0;
        exp_jobs++;
        n_checks++;
        if (res_valid !== 1'b1 || jobs_done !== 16'(exp_jobs)) begin
            n_fail++;
            $display("FAIL rst_retire: valid=%b jobs_done=%0d expected 1 %0d", res_valid, jobs_done, exp_jobs);
        end
    endtask

    initial begin
        rst = 1'b0;
        job_valid = 1'b0; job_x = '0; job_y = '0; job_z = '0; cnn_done = 1'b0; clr_err = 1'b0;
        w_job_valid = 1'b0; w_job_x = '0; w_job_y = '0; w_job_z = '0; w_cnn_done = 1'b0; w_clr_err = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stale_done();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t expected finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/cnn_job_dispatcher.md
# cnn_job_dispatcher

Initiator-side controller for the CNN accelerator's start/done job interface. It queues convolution jobs (x/y source addresses, z destination index) from a host or control FSM. It launches them one at a time into `CNN` with a single-cycle `start` pulse and holds the addresses stable until `done`. It reports per-job completion, keeps a completion count, and halts on a watchdog timeout. It sits between the system control path and the `CNN #(N)` instance, replacing the hand-driven stimulus used in bring-up.

## Interface
- `N`, 4, CNN parallelism; sets the address width.
- `AW`, `$clog2(N*16+256)`, width of x/y addresses (9 for N=4).
- `ZW`, 8, width of z index.
- `DEPTH`, 4, job FIFO depth (power of 2, ≥2).
- `TIMEOUT`, 4096, maximum cycles in WAIT before abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  host offers a job.
- `job_ready`  out  1  FIFO can accept; equals `!full`.
- `job_x`  in  AW  x source address.
- `job_y`  in  AW  y source address.
- `job_z`  in  ZW  z index.
- `cnn_start`  out  1  one-cycle launch pulse to `CNN.start`.
- `cnn_x`  out  AW  to `CNN.x_inp`; held from launch until retire.
- `cnn_y`  out  AW  to `CNN.y_inp`; held from launch until retire.
- `cnn_z`  out  ZW  to `CNN.z_inp`; held from launch until retire.
- `cnn_done`  in  1  `CNN.done`; level or pulse.
- `res_valid`  out  1  one-cycle pulse: a job retired.
- `res_timeout`  out  1  qualifies `res_valid`: 1 = job aborted by the watchdog.
- `jobs_done`  out  16  count of successfully retired jobs; wraps 0xFFFF→0.
- `busy`  out  1  state != IDLE or FIFO non-empty.
- `err`  out  1  sticky; set on timeout.
- `clr_err`  in  1  clears `err` and releases HALT.

## Operation
- FIFO: `DEPTH` entries of {x,y,z}. A push occurs on `job_valid && job_ready`. There is no bypass: a push when full is impossible because `job_ready=0`. Push and pop in the same cycle are allowed when neither full nor empty.
- States: IDLE, START, WAIT, HALT.
- IDLE: if the FIFO is non-empty, pop the head, register it into `cnn_x/y/z`, and go to START. Otherwise stay.
- START: `cnn_start=1` for exactly this cycle. Clear the watchdog counter. `cnn_done` is ignored. Next state is WAIT.
- WAIT: on `cnn_done=1`, go to IDLE, pulse `res_valid` with `res_timeout=0`, and increment `jobs_done`.
  - If the watchdog is enabled and the counter reaches `TIMEOUT-1` with `cnn_done=0`, go to HALT, set `err`, and pulse `res_valid` with `res_timeout=1`. `jobs_done` is unchanged.
  - If done and the timeout coincide, done wins.
- HALT: no launches. The FIFO keeps accepting jobs until full. `clr_err=1` clears `err` and moves to IDLE; queued jobs then resume.
- `clr_err` in any other state clears `err` only.
- `cnn_x/y/z` change only on the IDLE→START edge, so they are stable across the whole START/WAIT window.

## Timing
- Reset (`rst=0`, asynchronous): state=IDLE, FIFO empty, `job_ready=1`, `cnn_start=0`, `cnn_x/y/z=0`, `res_valid=0`, `res_timeout=0`, `jobs_done=0`, `busy=0`, `err=0`.
- Reset release is synchronous to `clk`, with no work in the first cycle.
- Reset mid-WAIT aborts the job silently: no `res_valid`, and the queue is lost.
- Push-to-launch latency with the FIFO empty and state IDLE: push at edge k, and `cnn_start` is high in the cycle after edge k+1.
- Done-to-`res_valid`: `cnn_done` sampled high at edge m, and `res_valid` is high in the cycle after edge m. `jobs_done` updates at the same edge.
- Back-to-back jobs: after retire there is one IDLE cycle, then START. The minimum start-to-start spacing is 3 cycles plus the CNN latency.
- A `cnn_done` still high from the previous job while in START is ignored. In WAIT a level `done` retires immediately, and the CNN must deassert `done` on `start`.
- The watchdog counts WAIT cycles only. An abort occurs exactly `TIMEOUT` cycles after entering WAIT.

## Test plan
- Single job: push {x=64,y=0,z=0} → `cnn_start` is one cycle wide 2 cycles after the push, and `cnn_x=64`, `cnn_y=0`, `cnn_z=0` are held. A model asserts `done` 20 cycles later → `res_valid=1`, `res_timeout=0`, `jobs_done=1`, `busy=0`.
- Back-to-back: push 3 jobs (x=64,128,192) in consecutive cycles → three launches in order, each `cnn_x` matching. Starts are separated by done latency + 3, and `jobs_done=3`.
- Backpressure: with the CNN stalled, push 6 jobs → the first is launched, 4 are queued, and `job_ready=0` on the 6th. After the first done, `job_ready` returns to 1 and all 6 complete in order.
- Timeout: `TIMEOUT=16` and `done` is never asserted → `res_valid`/`res_timeout=1` exactly 16 cycles after entering WAIT, `err=1`, and there are no further starts. `clr_err` pulse → the next queued job launches.
- Stale done: `cnn_done` held high through START → it is ignored in START. The job retires on the first WAIT cycle where `done=1`, and `jobs_done` increments once.
- Reset mid-WAIT: `rst=0` for 2 cycles during WAIT → all outputs are at reset values immediately, with no `res_valid`. A new push after release launches normally.
